// File: rtl/booth_ctrl.sv
// Control sequencer for a radix-2 Booth signed multiplier driving an external A/Q/M datapath.
// Moore machine: every output is a register loaded from the decode of the next state.
module booth_ctrl #(
   parameter int N = 8
) (
   input  logic clk,
   input  logic rst_b,
   input  logic start,
   input  logic q0,
   input  logic q_m1,
   output logic c0,
   output logic c1,
   output logic c2,
   output logic c3,
   output logic c4,
   output logic c5,
   output logic c6,
   output logic c7,
   output logic busy,
   output logic done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      INIT  = 4'd1,
      LOADQ = 4'd2,
      TEST  = 4'd3,
      ADD   = 4'd4,
      SUB   = 4'd5,
      SHIFT = 4'd6,
      OUT_A = 4'd7,
      OUT_Q = 4'd8,
      DONE  = 4'd9
   } state_t;

   state_t        state_r;
   state_t        next_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_next_s;
   logic [9:0]    out_r;

   // Output image per state, bit order {done, busy, c7..c0}; undefined encodings decode to all zero.
   function automatic logic [9:0] decode_out(input state_t st);
      logic [9:0] v;
      case (st)
         IDLE:    v = 10'b00_0000_0000;
         INIT:    v = 10'b01_0000_0011;
         LOADQ:   v = 10'b01_0000_1000;
         TEST:    v = 10'b01_0000_0000;
         ADD:     v = 10'b01_0000_0100;
         SUB:     v = 10'b01_0100_0100;
         SHIFT:   v = 10'b01_0001_0000;
         OUT_A:   v = 10'b01_0010_0000;
         OUT_Q:   v = 10'b01_1000_0000;
         DONE:    v = 10'b11_0000_0000;
         default: v = 10'b00_0000_0000;
      endcase
      return v;
   endfunction

   // Next-state and iteration-counter logic.
   always_comb begin
      next_s     = IDLE;
      cnt_next_s = cnt_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_s = INIT;
            end else begin
               next_s = IDLE;
            end
         end
         INIT: begin
            next_s     = LOADQ;
            cnt_next_s = {CW{1'b0}};
         end
         LOADQ: next_s = TEST;
         TEST: begin
            case ({q0, q_m1})
               2'b01:   next_s = ADD;
               2'b10:   next_s = SUB;
               default: next_s = SHIFT;
            endcase
         end
         ADD:   next_s = SHIFT;
         SUB:   next_s = SHIFT;
         SHIFT: begin
            // Explicit wrap keeps the counter legal when N is not a power of two.
            if (cnt_r == LAST_CNT) begin
               next_s     = OUT_A;
               cnt_next_s = {CW{1'b0}};
            end else begin
               next_s     = TEST;
               cnt_next_s = cnt_r + CW'(1);
            end
         end
         OUT_A: next_s = OUT_Q;
         OUT_Q: next_s = DONE;
         DONE:  next_s = IDLE;
         default: begin
            next_s     = IDLE;
            cnt_next_s = {CW{1'b0}};
         end
      endcase
   end

   // State, counter and registered outputs; async reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_r <= IDLE;
         cnt_r   <= {CW{1'b0}};
         out_r   <= 10'b00_0000_0000;
      end else begin
         state_r <= next_s;
         cnt_r   <= cnt_next_s;
         out_r   <= decode_out(next_s);
      end
   end

   assign c0   = out_r[0];
   assign c1   = out_r[1];
   assign c2   = out_r[2];
   assign c3   = out_r[3];
   assign c4   = out_r[4];
   assign c5   = out_r[5];
   assign c6   = out_r[6];
   assign c7   = out_r[7];
   assign busy = out_r[8];
   assign done = out_r[9];

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl: vector table of held {q0,q_m1} patterns plus
// hand-written reset, back-to-back and closed-loop datapath sequences.
module tb_booth_ctrl;

   logic clk = 1'b0;
   logic rst_b = 1'b1;
   logic start = 1'b0;
   logic q0, q_m1;
   logic q0_drv = 1'b0;
   logic q_m1_drv = 1'b0;
   logic use_dp = 1'b0;
   logic c0, c1, c2, c3, c4, c5, c6, c7, busy, done;
   logic [9:0] outs;

   logic [7:0] a_r = 8'h00;
   logic [7:0] q_r = 8'h00;
   logic [7:0] m_r = 8'h00;
   logic       qm1_r = 1'b0;
   logic [7:0] m_val = 8'hF9;
   logic [7:0] q_val = 8'h03;
   logic [7:0] inbus, obus;

   int errors = 0;
   int checks = 0;

   booth_ctrl #(.N(8)) dut (
      .clk(clk), .rst_b(rst_b), .start(start), .q0(q0), .q_m1(q_m1),
      .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   assign outs  = {done, busy, c7, c6, c5, c4, c3, c2, c1, c0};
   assign q0    = use_dp ? q_r[0] : q0_drv;
   assign q_m1  = use_dp ? qm1_r  : q_m1_drv;
   assign inbus = c1 ? m_val : q_val;
   assign obus  = c5 ? a_r : (c7 ? q_r : 8'h00);

   // Reference A/Q/M datapath obeying the control lines.
   always @(posedge clk) begin
      if (c0) begin
         a_r   <= 8'h00;
         qm1_r <= 1'b0;
      end
      if (c1) m_r <= inbus;
      if (c3) q_r <= inbus;
      if (c2) a_r <= c6 ? (a_r - m_r) : (a_r + m_r);
      if (c4) begin
         a_r   <= {a_r[7], a_r[7:1]};
         q_r   <= {a_r[0], q_r[7:1]};
         qm1_r <= q_r[0];
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // One operation from a single start pulse; counts per-cycle activity while busy.
   task automatic run_op(input logic [1:0] qq, input bit poke,
                         output int cycles, output int c2n, output int c6n, output int c4n,
                         output int donen, output int last_done, output int excl);
      q0_drv = qq[1];
      q_m1_drv = qq[0];
      cycles = 0; c2n = 0; c6n = 0; c4n = 0; donen = 0; last_done = 0; excl = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (busy && cycles < 100) begin
         cycles++;
         if (c2) c2n++;
         if (c2 && c6) c6n++;
         if (c4) c4n++;
         if (done) donen++;
         last_done = int'(done);
         if ((c2 && c4) || (c5 && c7)) excl++;
         if (poke && (cycles % 4 == 2) && cycles < 16) start = 1'b1;
         else start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   typedef struct {
      logic [1:0] qq;
      bit         poke;
      int         cycles;
      int         c2n;
      int         c6n;
      int         c4n;
   } vec_t;

   initial begin
      vec_t vecs[5];
      int cyc, c2n, c6n, c4n, donen, last_done, excl;
      int t_init1, t_done, t_init2, n, busy_seen, done_seen;

      vecs[0] = '{2'b00, 1'b0, 21, 0, 0, 8};
      vecs[1] = '{2'b01, 1'b0, 29, 8, 0, 8};
      vecs[2] = '{2'b10, 1'b0, 29, 8, 8, 8};
      vecs[3] = '{2'b11, 1'b0, 21, 0, 0, 8};
      vecs[4] = '{2'b00, 1'b1, 21, 0, 0, 8};

      #2 rst_b = 1'b0;
      #1 chk("reset_outputs", int'(outs), 0);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      chk("idle_outputs", int'(outs), 0);

      foreach (vecs[i]) begin
         run_op(vecs[i].qq, vecs[i].poke, cyc, c2n, c6n, c4n, donen, last_done, excl);
         chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cycles);
         chk($sformatf("v%0d_c2", i), c2n, vecs[i].c2n);
         chk($sformatf("v%0d_sub", i), c6n, vecs[i].c6n);
         chk($sformatf("v%0d_c4", i), c4n, vecs[i].c4n);
         chk($sformatf("v%0d_done_cnt", i), donen, 1);
         chk($sformatf("v%0d_done_last", i), last_done, 1);
         chk($sformatf("v%0d_exclusive", i), excl, 0);
      end

      // Asynchronous reset while in SUB aborts the operation.
      q0_drv = 1'b1;
      q_m1_drv = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(c2 && c6) && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("sub_reached", int'(c2 && c6), 1);
      #1 rst_b = 1'b0;
      #1 chk("reset_in_sub", int'(outs), 0);
      #1 rst_b = 1'b1;
      busy_seen = 0;
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy) busy_seen++;
         if (done) done_seen++;
      end
      chk("post_reset_busy", busy_seen, 0);
      chk("post_reset_done", done_seen, 0);

      // start held high across two operations.
      q0_drv = 1'b0;
      q_m1_drv = 1'b0;
      @(negedge clk);
      start = 1'b1;
      t_init1 = -1; t_done = -1; t_init2 = -1;
      for (int i = 0; i < 80 && t_init2 < 0; i++) begin
         @(negedge clk);
         if (c0 && t_init1 < 0) t_init1 = i;
         else if (done && t_done < 0) t_done = i;
         else if (c0 && t_done >= 0 && t_init2 < 0) t_init2 = i;
      end
      start = 1'b0;
      chk("b2b_first_len", t_done - t_init1 + 1, 21);
      chk("b2b_gap", t_init2 - t_done, 2);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("b2b_idle", int'(busy), 0);

      // Closed loop: -7 * 3 = -21.
      use_dp = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!c5 && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("out_a_seen", int'(c5), 1);
      chk("obus_a", int'(obus), 8'hFF);
      @(negedge clk);
      chk("out_q_seen", int'(c7), 1);
      chk("obus_q", int'(obus), 8'hEB);
      @(negedge clk);
      chk("final_done", int'(done), 1);
      @(negedge clk);
      chk("final_idle", int'(outs), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/booth_ctrl.md
BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 Parameter: N, 8, number of Booth iterations; operand width of the A/Q/M datapath.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new signed multiply; sampled only in IDLE.
REQ-005 q0  input  1  current Q[0] from the Q register.
REQ-006 q_m1  input  1  current Q[-1] (Booth extra bit).
REQ-007 c0  output  1  clear A, Q[-1] (datapath), iteration counter (internal).
REQ-008 c1  output  1  load M from inbus.
REQ-009 c2  output  1  load A from adder sum.
REQ-010 c3  output  1  load Q from inbus.
REQ-011 c4  output  1  arithmetic shift right of A:Q:Q[-1].
REQ-012 c5  output  1  drive A onto obus.
REQ-013 c6  output  1  adder select: 1 = A - M, 0 = A + M; meaningful only while c2=1.
REQ-014 c7  output  1  drive Q onto obus.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse marking end of operation.

Function
REQ-017 Moore FSM; every output SHALL be decoded from the registered state only, with no combinational path from inputs to outputs.
REQ-018 States: IDLE, INIT, LOADQ, TEST, ADD, SUB, SHIFT, OUT_A, OUT_Q, DONE.
REQ-019 Outputs per state: IDLE none; INIT c0,c1; LOADQ c3; TEST none; ADD c2 (c6=0); SUB c2,c6; SHIFT c4; OUT_A c5; OUT_Q c7; DONE done. All unlisted c* SHALL be 0.
REQ-020 IDLE -> INIT when start=1, else stay IDLE; INIT -> LOADQ -> TEST unconditionally.
REQ-021 TEST decodes {q0,q_m1}, sampled on the edge leaving TEST: 01 -> ADD; 10 -> SUB; 00 or 11 -> SHIFT.
REQ-022 ADD -> SHIFT and SUB -> SHIFT unconditionally.
REQ-023 Iteration counter width $clog2(N): cleared on the edge leaving INIT, incremented on each edge leaving SHIFT.
REQ-024 SHIFT -> OUT_A when counter = N-1 before increment (counter wraps to 0), else SHIFT -> TEST.
REQ-025 OUT_A -> OUT_Q -> DONE -> IDLE unconditionally.
REQ-026 Exactly N c4 pulses and at most N c2 pulses per operation.
REQ-027 Operation length from INIT through DONE inclusive: 2 + 2N + k + 3 cycles, where k = number of ADD/SUB visits (N=8: 21 min, 29 max).
REQ-028 start while busy=1 SHALL be ignored with no effect on state or counter; no queuing.
REQ-029 start held high SHALL re-enter INIT on the edge after the one IDLE cycle following DONE.
REQ-030 c2 and c4 SHALL never be asserted in the same cycle; c5 and c7 SHALL never be asserted in the same cycle.
REQ-031 Unreachable state encodings SHALL transition to IDLE on the next edge with all outputs 0.

Reset
REQ-032 rst_b=0 SHALL force IDLE and counter=0, and drive c0..c7, busy and done to 0 immediately, independent of clk.
REQ-033 Reset asserted mid-operation SHALL abort it without a done pulse; after release the FSM waits in IDLE for start.

Verification
REQ-034 Reset during SUB (rst_b=0 between edges) -> all outputs 0 before the next edge; after release with start=0, busy stays 0.
REQ-035 start=1 one cycle, {q0,q_m1}=00 held -> sequence INIT, LOADQ, 8x(TEST,SHIFT), OUT_A, OUT_Q, DONE; 21 cycles; c2 never asserted; c4 pulses = 8.
REQ-036 {q0,q_m1}=01 held -> each TEST followed by ADD (c2=1,c6=0); 29 cycles; c2 pulses = 8.
REQ-037 {q0,q_m1}=10 held -> each TEST followed by SUB (c2=1,c6=1); 29 cycles; done pulses once at cycle 29.
REQ-038 start held high across two operations -> second INIT exactly 2 cycles after first DONE; start pulses during busy leave the cycle count unchanged.
REQ-039 Closed loop with A/Q/M datapath model: M=0xF9 (-7), Q=0x03 -> obus 0xFF during OUT_A, 0xEB during OUT_Q (-21).
